robo_ambiente: RTL
==================

# robo_ambiente

Grid-world environment model that closes the loop around the wall-following robot controller: it consumes the controller's `avancar`/`girar` commands and produces the `head`/`left` wall-sensor inputs. It tracks robot position and heading on a parameterised cell map. It flags illegal moves, goal arrival and move count. It is the testbench-side and FPGA-demo counterpart of the controller, running on the same clock and update cadence.

## Interface
- `GRID_W`, 8: map width in cells (≥2)
- `GRID_H`, 8: map height in cells (≥2)
- `MAP`, 0: `GRID_W*GRID_H`-bit wall map; bit `y*GRID_W+x` = 1 means wall cell
- `START_X`, `START_Y`, 0/0: reset position; must be a free cell
- `START_DIR`, 1: reset heading; 0=N (y−1), 1=E (x+1), 2=S (y+1), 3=W (x−1)
- `GOAL_X`, `GOAL_Y`, `GRID_W-1`/`GRID_H-1`: goal cell
- `STEP_DIV`, 3: clock cycles per world update; matches the controller's state-update cadence
- `clock`  in  1  rising-edge clock
- `reset`  in  1  synchronous, active-high
- `avancar`  in  1  move-forward command
- `girar`  in  1  rotate-90°-clockwise command
- `head`  out  1  cell ahead is wall or outside the grid
- `left`  out  1  cell to the left is wall or outside the grid
- `pos_x`  out  `$clog2(GRID_W)`  current x
- `pos_y`  out  `$clog2(GRID_H)`  current y
- `dir`  out  2  current heading
- `crash`  out  1  sticky; a forward move into a blocked cell was attempted
- `cmd_err`  out  1  one-cycle pulse; both commands were high at an update
- `done`  out  1  sticky; robot is on the goal cell
- `moves`  out  16  successful forward moves, saturating at 16'hFFFF
- `visit_cnt`  out  16  distinct cells visited (see Configuration)

## Operation
- **Prescaler:** `div_cnt` counts 0..`STEP_DIV`−1 and wraps. An update (tick) occurs on the edge where `div_cnt == STEP_DIV-1`. Commands are sampled only at ticks.
- **Command priority at a tick:**
  - `done`=1: hold everything; the world is frozen.
  - `girar`=1: `dir <= dir+1` (mod 4). If `avancar` is also 1, no move occurs and `cmd_err` pulses.
  - `avancar`=1 only:
    - Ahead free: step one cell and `moves` increments.
    - Ahead blocked: position holds and `crash` is set.
  - Neither: hold.
- **Goal:** after a move whose destination is (`GOAL_X`,`GOAL_Y`), `done` is set. A start cell equal to the goal gives `done`=1 out of reset.
- **Sensors:** combinational from registered `pos`/`dir`/`MAP`.
  - `head` looks at the neighbour in `dir`.
  - `left` looks at the neighbour in `(dir+3) mod 4`.
  - Any out-of-range coordinate (x=0 going W, x=`GRID_W-1` going E, same for y) reads as wall. No wrap-around.
- **Bounds arithmetic:** compute neighbours at one bit wider than `pos_x`/`pos_y` so that underflow and overflow are detected.
- **Start cell is a wall:** simulation `$error` at time 0; hardware behaviour is undefined.

## Timing
- **Reset values:**
  - `pos` = START, `dir` = `START_DIR`, `div_cnt` = 0.
  - `crash` = 0, `cmd_err` = 0, `moves` = 0.
  - `done` = (start==goal).
  - `visit_cnt` = 1 (macro on) or 0 (macro off).
- **First tick:** occurs on the `STEP_DIV`-th rising edge after the edge at which reset is sampled low.
- **Update latency:** `pos`/`dir`/`moves` change on the tick edge. `head`/`left` reflect the new state in the same cycle, so they are valid for the controller's next update.
- **`cmd_err`:** high exactly one cycle, the cycle after the tick edge.
- **Reset mid-count:** `div_cnt` restarts and all state returns to reset values on that edge.

## Configuration
- `ROBO_AMBIENTE_VISIT_EN`
  - **Defined:** adds a `GRID_W*GRID_H` visited bitmap (start cell set at reset). Each successful move into an unvisited cell sets its bit and increments `visit_cnt` (saturating).
  - **Undefined:** no bitmap is built and `visit_cnt` is tied to 0. All other behaviour is identical.

## Test plan
All scenarios use `GRID_W`=`GRID_H`=4, `MAP`=0, start (0,0), `START_DIR`=1, goal (3,3), `STEP_DIV`=3.
- **Reset state:** release reset -> `pos`=(0,0), `dir`=1, `head`=0, `left`=1, `moves`=0, `done`=0, `visit_cnt`=1 (macro on).
- **Forward run:** `avancar`=1 for 9 cycles -> `pos` changes only on cycles 3, 6 and 9, ending at (3,0), `head`=1, `moves`=3, `visit_cnt`=4.
- **Crash:** hold `avancar` 3 more cycles -> `crash`=1, `pos`=(3,0), `moves`=3.
- **Rotate:** `girar`=1 for one tick -> `dir`=2, `head`=0, `left`=1. Then `avancar` 9 cycles -> `pos`=(3,3), `done`=1. Further commands leave `pos`, `dir` and `moves`=6 unchanged.
- **Conflict:** `avancar`=`girar`=1 at a tick -> `dir` increments, `pos` holds, `cmd_err` high for exactly 1 cycle.
- **Reset mid-operation:** assert `reset` with `div_cnt`=1 after 2 moves -> all reset values are restored. The next tick lands exactly 3 edges after reset is released.

Source files
------------

// File: rtl/robo_ambiente.sv
// -----------------------------------------------------------------------------
// robo_ambiente
//
// Grid-world environment for the wall-following robot controller. It consumes
// the controller's move/rotate commands, tracks the robot's cell position and
// heading on a fixed wall map, and drives the controller's wall sensors.
//
// World updates happen once every STEP_DIV clocks (a "tick"), so the
// environment advances at the same rate as the controller's state updates.
//
// Parameters
//   GRID_W, GRID_H      map size in cells (each >= 2)
//   MAP                 GRID_W*GRID_H wall bitmap, bit y*GRID_W+x = 1 is a wall
//   START_X, START_Y    reset position (must be a free cell)
//   START_DIR           reset heading: 0=N (y-1), 1=E (x+1), 2=S (y+1), 3=W (x-1)
//   GOAL_X, GOAL_Y      goal cell
//   STEP_DIV            clocks per world update
//
// Ports
//   clock       rising-edge clock
//   reset       synchronous, active-high reset
//   avancar     move-forward command (sampled at ticks only)
//   girar       rotate 90 degrees clockwise (sampled at ticks only)
//   head        cell ahead is a wall or outside the grid
//   left        cell to the left is a wall or outside the grid
//   pos_x/pos_y current position
//   dir         current heading
//   crash       sticky: a forward move into a blocked cell was attempted
//   cmd_err     one-cycle pulse: both commands were high at a tick
//   done        sticky: robot reached the goal; the world is then frozen
//   moves       successful forward moves, saturating at 16'hFFFF
//   visit_cnt   distinct cells visited (0 when the visit tracker is not built)
//
// Build option
//   ROBO_AMBIENTE_VISIT_EN  when defined, a visited-cell bitmap is kept and
//                           visit_cnt counts distinct cells entered (start
//                           cell included). When undefined, visit_cnt is 0.
// -----------------------------------------------------------------------------
module robo_ambiente #(
    parameter int                       GRID_W    = 8,
    parameter int                       GRID_H    = 8,
    parameter logic [GRID_W*GRID_H-1:0] MAP       = '0,
    parameter int                       START_X   = 0,
    parameter int                       START_Y   = 0,
    parameter int                       START_DIR = 1,
    parameter int                       GOAL_X    = GRID_W - 1,
    parameter int                       GOAL_Y    = GRID_H - 1,
    parameter int                       STEP_DIV  = 3
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic                        avancar,
    input  logic                        girar,
    output logic                        head,
    output logic                        left,
    output logic [$clog2(GRID_W)-1:0]   pos_x,
    output logic [$clog2(GRID_H)-1:0]   pos_y,
    output logic [1:0]                  dir,
    output logic                        crash,
    output logic                        cmd_err,
    output logic                        done,
    output logic [15:0]                 moves,
    output logic [15:0]                 visit_cnt
);

    localparam int XW    = $clog2(GRID_W);
    localparam int YW    = $clog2(GRID_H);
    localparam int NCELL = GRID_W * GRID_H;
    localparam int IW    = $clog2(NCELL);
    localparam int DW    = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;

    localparam logic DONE_AT_START = (START_X == GOAL_X) && (START_Y == GOAL_Y);

    // A wall under the start cell is a configuration mistake; flag it while
    // the design is being elaborated rather than letting it run silently.
    if (MAP[START_Y*GRID_W + START_X]) begin : g_bad_start
        $error("robo_ambiente: start cell (%0d,%0d) is a wall", START_X, START_Y);
    end

    // -------------------------------------------------------------------------
    // Neighbour arithmetic. Coordinates are widened by one bit so that both a
    // step below zero (wraps to all ones) and a step past the last column/row
    // land at a value >= the grid size and are recognised as outside.
    // -------------------------------------------------------------------------
    function automatic logic [XW:0] step_x(input logic [XW-1:0] x, input logic [1:0] d);
        logic [XW:0] r;
        r = {1'b0, x};
        if (d == 2'd1)
            r = r + (XW+1)'(1);
        else if (d == 2'd3)
            r = r - (XW+1)'(1);
        return r;
    endfunction

    function automatic logic [YW:0] step_y(input logic [YW-1:0] y, input logic [1:0] d);
        logic [YW:0] r;
        r = {1'b0, y};
        if (d == 2'd2)
            r = r + (YW+1)'(1);
        else if (d == 2'd0)
            r = r - (YW+1)'(1);
        return r;
    endfunction

    function automatic logic [IW-1:0] cell_index(input logic [XW:0] cx, input logic [YW:0] cy);
        return IW'(int'(cy) * GRID_W + int'(cx));
    endfunction

    // Anything outside the grid behaves as a wall; there is no wrap-around.
    function automatic logic is_blocked(input logic [XW:0] cx, input logic [YW:0] cy);
        if (int'(cx) >= GRID_W || int'(cy) >= GRID_H)
            return 1'b1;
        return MAP[cell_index(cx, cy)];
    endfunction

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    logic [DW-1:0] div_cnt_reg, div_cnt_next;
    logic [XW-1:0] pos_x_reg,   pos_x_next;
    logic [YW-1:0] pos_y_reg,   pos_y_next;
    logic [1:0]    dir_reg,     dir_next;
    logic          crash_reg,   crash_next;
    logic          cmd_err_reg, cmd_err_next;
    logic          done_reg,    done_next;
    logic [15:0]   moves_reg,   moves_next;

    logic          tick;
    logic          move_ok;

    // Cell ahead (in dir) and cell to the left (dir rotated counter-clockwise)
    logic [XW:0]   head_x, left_x;
    logic [YW:0]   head_y, left_y;
    logic          head_blk, left_blk;
    logic [1:0]    left_dir;

    assign left_dir = dir_reg + 2'd3;
    assign head_x   = step_x(pos_x_reg, dir_reg);
    assign head_y   = step_y(pos_y_reg, dir_reg);
    assign left_x   = step_x(pos_x_reg, left_dir);
    assign left_y   = step_y(pos_y_reg, left_dir);
    assign head_blk = is_blocked(head_x, head_y);
    assign left_blk = is_blocked(left_x, left_y);

    assign tick = (div_cnt_reg == DW'(STEP_DIV - 1));

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        div_cnt_next = tick ? '0 : div_cnt_reg + DW'(1);
        pos_x_next   = pos_x_reg;
        pos_y_next   = pos_y_reg;
        dir_next     = dir_reg;
        crash_next   = crash_reg;
        cmd_err_next = 1'b0;
        done_next    = done_reg;
        move_ok      = 1'b0;

        // Once the goal is reached the world is frozen: no rotation, no
        // movement, no crash or command-error reporting.
        if (tick && !done_reg) begin
            if (girar) begin
                // Rotation wins over a simultaneous move; the conflict is flagged.
                dir_next     = dir_reg + 2'd1;
                cmd_err_next = avancar;
            end else if (avancar) begin
                if (head_blk) begin
                    crash_next = 1'b1;
                end else begin
                    move_ok    = 1'b1;
                    pos_x_next = head_x[XW-1:0];
                    pos_y_next = head_y[YW-1:0];
                    if (head_x == (XW+1)'(GOAL_X) && head_y == (YW+1)'(GOAL_Y))
                        done_next = 1'b1;
                end
            end
        end

        moves_next = (move_ok && moves_reg != 16'hFFFF) ? moves_reg + 16'd1 : moves_reg;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            div_cnt_reg <= '0;
            pos_x_reg   <= XW'(START_X);
            pos_y_reg   <= YW'(START_Y);
            dir_reg     <= 2'(START_DIR);
            crash_reg   <= 1'b0;
            cmd_err_reg <= 1'b0;
            done_reg    <= DONE_AT_START;
            moves_reg   <= 16'd0;
        end else begin
            div_cnt_reg <= div_cnt_next;
            pos_x_reg   <= pos_x_next;
            pos_y_reg   <= pos_y_next;
            dir_reg     <= dir_next;
            crash_reg   <= crash_next;
            cmd_err_reg <= cmd_err_next;
            done_reg    <= done_next;
            moves_reg   <= moves_next;
        end
    end

    // -------------------------------------------------------------------------
    // Optional visited-cell tracking
    // -------------------------------------------------------------------------
`ifdef ROBO_AMBIENTE_VISIT_EN
    localparam int START_IDX = START_Y * GRID_W + START_X;

    logic [NCELL-1:0] visited_vec;
    logic [IW-1:0]    ahead_idx;
    logic [15:0]      visit_cnt_reg;

    // Only meaningful when move_ok is set, i.e. the cell ahead is on the grid.
    assign ahead_idx = cell_index(head_x, head_y);

    genvar gi;
    for (gi = 0; gi < NCELL; gi++) begin : g_visit
        logic v_reg;
        always_ff @(posedge clock) begin
            if (reset)
                v_reg <= (gi == START_IDX);
            else if (move_ok && ahead_idx == IW'(gi))
                v_reg <= 1'b1;
        end
        assign visited_vec[gi] = v_reg;
    end

    always_ff @(posedge clock) begin
        if (reset)
            visit_cnt_reg <= 16'd1;
        else if (move_ok && !visited_vec[ahead_idx] && visit_cnt_reg != 16'hFFFF)
            visit_cnt_reg <= visit_cnt_reg + 16'd1;
    end

    assign visit_cnt = visit_cnt_reg;
`else
    assign visit_cnt = 16'd0;
`endif

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign head    = head_blk;
    assign left    = left_blk;
    assign pos_x   = pos_x_reg;
    assign pos_y   = pos_y_reg;
    assign dir     = dir_reg;
    assign crash   = crash_reg;
    assign cmd_err = cmd_err_reg;
    assign done    = done_reg;
    assign moves   = moves_reg;

endmodule
